// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter: a CPU (read/write) and a VGA fetcher (read-only) share one SRAM.
// VGA normally wins, but a starvation counter guarantees the CPU a grant after a bounded run.
module sram_arbiter #(
    parameter int unsigned DW            = 16,
    parameter int unsigned AW            = 16,
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_dout,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_ack,
    output logic [DW-1:0] vga_dout,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_dout,
    output logic          busy
);

    localparam int unsigned CntW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] CntLast   = CntW'(ACCESS_CYCLES - 1);
    localparam logic [StW-1:0]  StarveMax = StW'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e          state_q, state_d;
    logic            owner_cpu_q, owner_cpu_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   din_q, din_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [StW-1:0]  starve_q, starve_d;
    logic [DW-1:0]   cpu_dout_q, cpu_dout_d;
    logic [DW-1:0]   vga_dout_q, vga_dout_d;
    logic            cpu_win, vga_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_cpu_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            cnt_q       <= '0;
            starve_q    <= '0;
            cpu_dout_q  <= '0;
            vga_dout_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_cpu_q <= owner_cpu_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            cpu_dout_q  <= cpu_dout_d;
            vga_dout_q  <= vga_dout_d;
        end
    end

    // CPU takes the slot only when VGA is absent or has used up its consecutive-grant allowance.
    assign cpu_win = cpu_req && (!vga_req || (starve_q == StarveMax));
    assign vga_win = vga_req && !cpu_win;

    always_comb begin
        state_d     = state_q;
        owner_cpu_d = owner_cpu_q;
        we_d        = we_q;
        addr_d      = addr_q;
        din_d       = din_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        cpu_dout_d  = cpu_dout_q;
        vga_dout_d  = vga_dout_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (cpu_win) begin
                    owner_cpu_d = 1'b1;
                    we_d        = cpu_we;
                    addr_d      = cpu_addr;
                    din_d       = cpu_din;
                    starve_d    = '0;
                    state_d     = StAccess;
                end else if (vga_win) begin
                    owner_cpu_d = 1'b0;
                    we_d        = 1'b0;
                    addr_d      = vga_addr;
                    state_d     = StAccess;
                    if (!cpu_req) begin
                        starve_d = '0;
                    end else if (starve_q != StarveMax) begin
                        starve_d = starve_q + StW'(1);
                    end
                end else begin
                    starve_d = '0;
                end
            end
            StAccess: begin
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    if (!we_q) begin
                        if (owner_cpu_q) begin
                            cpu_dout_d = sram_dout;
                        end else begin
                            vga_dout_d = sram_dout;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign sram_ce_n = (state_q != StAccess);
    assign sram_oe_n = !((state_q == StAccess) && !we_q);
    assign sram_we_n = !((state_q == StAccess) && we_q);
    assign sram_addr = addr_q;
    assign sram_din  = din_q;
    assign cpu_ack   = (state_q == StDone) && owner_cpu_q;
    assign vga_ack   = (state_q == StDone) && !owner_cpu_q;
    assign cpu_dout  = cpu_dout_q;
    assign vga_dout  = vga_dout_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed requests, an SRAM model, and an ack scoreboard that checks
// grant order and returned data independently of the stimulus.
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, vga_req;
    logic [15:0] cpu_addr, cpu_din, vga_addr;
    logic        cpu_ack, vga_ack;
    logic [15:0] cpu_dout, vga_dout;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic [15:0] sram_addr, sram_din, sram_dout;
    logic        busy;

    sram_arbiter #(
        .DW(16), .AW(16), .ACCESS_CYCLES(2), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack), .vga_dout(vga_dout),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
        .busy(busy)
    );

    typedef struct packed {
        logic        cpu;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          cpu_ack_cyc, vga_ack_cyc;
    logic [15:0] last_addr;
    logic [15:0] mem [0:65535];
    bit          loaded = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: async read while ce/oe low, write on the edge while ce/we low.
    assign sram_dout = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 8; i++) mem[i] <= 16'h1000 + 16'(i);
            mem[16'h0100] <= 16'h5555;
            mem[16'h0200] <= 16'h1234;
            mem[16'h0300] <= 16'hAAAA;
            mem[16'h0400] <= 16'h4444;
            mem[16'hFFFF] <= 16'hF00D;
            loaded <= 1'b1;
        end else if (!sram_ce_n && !sram_we_n) begin
            mem[sram_addr] <= sram_din;
        end
    end

    always @(negedge clk) if (!sram_ce_n) last_addr = sram_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every ack must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        logic [15:0] got;
        if (!rst && (cpu_ack || vga_ack)) begin
            total++;
            got = cpu_ack ? cpu_dout : vga_dout;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ack: actual cpu_ack=%0d vga_ack=%0d required none",
                         cpu_ack, vga_ack);
            end else begin
                e = exp_q.pop_front();
                if ((cpu_ack !== e.cpu) || (cpu_ack && vga_ack) || (got !== e.data)) begin
                    bad++;
                    $display("FAIL ack_check: actual cpu=%0d vga=%0d data=%h required cpu=%0d data=%h",
                             cpu_ack, vga_ack, got, e.cpu, e.data);
                end
            end
        end
    end

    // Raise the selected requests and drop each on the edge where its ack is sampled.
    task automatic run(input bit c, input bit v);
        bit pend_c = c;
        bit pend_v = v;
        int n = 0;
        cpu_req = c;
        vga_req = v;
        while ((pend_c || pend_v) && n < 50) begin
            @(negedge clk);
            n++;
            if (cpu_ack) begin pend_c = 0; cpu_ack_cyc = cyc; end
            if (vga_ack) begin pend_v = 0; vga_ack_cyc = cyc; end
            @(posedge clk);
            #1;
            if (!pend_c) cpu_req = 0;
            if (!pend_v) vga_req = 0;
        end
        if (pend_c || pend_v) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: actual pending cpu=%0d vga=%0d required 0 0", pend_c, pend_v);
            cpu_req = 0;
            vga_req = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int cpu_n;
        bit va, ca;
        rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_din = 0; vga_req = 0; vga_addr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
        check("rst_busy", 32'(busy), 0);
        check("rst_acks", 32'({cpu_ack, vga_ack}), 0);
        check("rst_douts", {cpu_dout, vga_dout}, 0);
        check("rst_addr_din", {sram_addr, sram_din}, 0);
        @(posedge clk); #1 rst = 0;

        // CPU write 0x0010 <= 0xBEEF with cycle-exact strobe checks
        cpu_we = 1; cpu_addr = 16'h0010; cpu_din = 16'hBEEF; cpu_req = 1;
        exp_q.push_back('{cpu: 1'b1, data: 16'h0000});
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("wr_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h2);
            check("wr_addr_din", {sram_addr, sram_din}, 32'h0010_BEEF);
        end
        @(negedge clk);
        check("wr_ack_cycle", 32'({cpu_ack, sram_ce_n, busy}), 32'h7);
        @(posedge clk); #1 cpu_req = 0;
        check("wr_mem", 32'(mem[16'h0010]), 32'hBEEF);

        // CPU read back
        cpu_we = 0;
        exp_q.push_back('{cpu: 1'b1, data: 16'hBEEF});
        run(1, 0);

        // Simultaneous: VGA first, CPU exactly 4 cycles later
        cpu_addr = 16'h0100; vga_addr = 16'h0200;
        exp_q.push_back('{cpu: 1'b0, data: 16'h1234});
        exp_q.push_back('{cpu: 1'b1, data: 16'h5555});
        run(1, 1);
        check("simul_spacing", 32'(cpu_ack_cyc - vga_ack_cyc), 4);

        // Isolation between the two dout registers
        vga_addr = 16'h0300;
        exp_q.push_back('{cpu: 1'b0, data: 16'hAAAA});
        run(0, 1);
        check("iso_cpu_dout", 32'(cpu_dout), 32'h5555);
        cpu_we = 1; cpu_addr = 16'h0120; cpu_din = 16'h7777;
        exp_q.push_back('{cpu: 1'b1, data: 16'h5555});
        run(1, 0);
        check("iso_vga_dout", 32'(vga_dout), 32'hAAAA);
        cpu_we = 0;

        // Boundary addresses
        vga_addr = 16'hFFFF;
        exp_q.push_back('{cpu: 1'b0, data: 16'hF00D});
        run(0, 1);
        check("bound_addr_hi", 32'(last_addr), 32'hFFFF);
        cpu_addr = 16'h0000;
        exp_q.push_back('{cpu: 1'b1, data: 16'h1000});
        run(1, 0);
        check("bound_addr_lo", 32'(last_addr), 32'h0000);

        // Starvation: both held, expect VGA x4, CPU, VGA x4, CPU
        for (int i = 0; i < 4; i++) exp_q.push_back('{cpu: 1'b0, data: 16'h1000 + 16'(i)});
        exp_q.push_back('{cpu: 1'b1, data: 16'h4444});
        for (int i = 4; i < 8; i++) exp_q.push_back('{cpu: 1'b0, data: 16'h1000 + 16'(i)});
        exp_q.push_back('{cpu: 1'b1, data: 16'h4444});
        cpu_addr = 16'h0400; vga_addr = 16'h0000; cpu_req = 1; vga_req = 1;
        n = 0; cpu_n = 0;
        while (cpu_n < 2 && n < 200) begin
            @(negedge clk);
            n++;
            va = vga_ack; ca = cpu_ack;
            @(posedge clk); #1;
            if (va) vga_addr = vga_addr + 16'h1;
            if (ca) cpu_n++;
        end
        cpu_req = 0; vga_req = 0;
        check("starve_cpu_grants", 32'(cpu_n), 2);
        check("starve_vga_grants", 32'(vga_addr), 8);
        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 0);

        // Reset during the first ACCESS cycle of a CPU write
        cpu_we = 1; cpu_addr = 16'h0500; cpu_din = 16'h9999; cpu_req = 1;
        @(posedge clk); #1;
        check("abort_in_access", 32'(sram_ce_n), 0);
        rst = 1; cpu_req = 0;
        @(negedge clk); @(negedge clk);
        check("abort_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
        check("abort_busy_ack", 32'({busy, cpu_ack, vga_ack}), 0);
        check("abort_douts", {cpu_dout, vga_dout}, 0);
        @(posedge clk); #1 rst = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("abort_idle", 32'({busy, cpu_ack}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external SRAM between two requesters: the CPU (read/write) and the VGA controller (read-only).
- Sits between the requesters and the SRAM strobes/address/data pins, in place of direct CPU strobe control.
- Performs one fixed-length SRAM access per grant.
- VGA has priority (real-time fetch), bounded by an anti-starvation limit so the CPU always progresses.

Parameters:
- DW, 16, data width (matches DATAWIDTH)
- AW, 16, SRAM address width
- ACCESS_CYCLES, 2, cycles strobes are held asserted per access (>=1)
- STARVE_LIMIT, 4, max consecutive VGA grants while cpu_req is pending (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cpu_req  in  1  CPU access request, level; held until cpu_ack
- cpu_we  in  1  1=write, 0=read; valid with cpu_req
- cpu_addr  in  AW  CPU address
- cpu_din  in  DW  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_dout  out  DW  registered CPU read data
- vga_req  in  1  VGA read request, level; held until vga_ack
- vga_addr  in  AW  VGA read address
- vga_ack  out  1  one-cycle completion pulse
- vga_dout  out  DW  registered VGA read data
- sram_ce_n  out  1  SRAM chip enable, active-low
- sram_oe_n  out  1  SRAM output enable, active-low
- sram_we_n  out  1  SRAM write enable, active-low
- sram_addr  out  AW  SRAM address
- sram_din  out  DW  write data to SRAM
- sram_dout  in  DW  read data from SRAM
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; sram_ce_n/oe_n/we_n=1; sram_addr=0; sram_din=0
  - cpu_ack=vga_ack=0; cpu_dout=vga_dout=0; starve counter=0
  - Reset during an access aborts it: no ack; strobes high from the next cycle.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If no request, stay in IDLE with strobes high.
  - Otherwise pick a winner and latch owner, we, addr and din into registers; go to ACCESS.
  - A winning VGA access always has we=0.
- Arbitration:
  - VGA wins if vga_req=1, unless cpu_req=1 and starve counter==STARVE_LIMIT; then the CPU wins.
  - Starve counter increments on each VGA grant made while cpu_req=1.
  - It clears on any CPU grant, or in any IDLE cycle where cpu_req=0.
  - It saturates at STARVE_LIMIT.
- ACCESS (exactly ACCESS_CYCLES cycles):
  - sram_ce_n=0; sram_addr=latched address.
  - Read: sram_oe_n=0, sram_we_n=1.
  - Write: sram_we_n=0, sram_oe_n=1, sram_din=latched data.
  - Last ACCESS cycle, read: sram_dout is captured into the owner's dout register.
  - The other requester's dout is unchanged; writes leave cpu_dout unchanged.
- DONE (1 cycle): all strobes high; owner's ack=1; dout is already valid; next state IDLE.
- Latency:
  - Request sampled in IDLE at edge E.
  - Strobes asserted for cycles E+1..E+ACCESS_CYCLES.
  - ack high in cycle E+ACCESS_CYCLES+1.
  - Back-to-back grant spacing is ACCESS_CYCLES+2 cycles.
- Handshake:
  - Requester holds req/addr/we/din stable until it samples ack=1, then drops req on that same edge.
  - Changes to req inputs after the grant are ignored until the next IDLE.
  - A req still high in IDLE is treated as a new request.
- Simultaneous requests: resolved by the arbitration rule above. No request is lost; the loser stays pending.
- Address: passed through unmodified; 0 and 2^AW-1 are valid, with no wrap logic.

Test Plan:
- CPU write: cpu_req=1, we=1, addr=0x0010, din=0xBEEF with vga_req=0 -> sram_ce_n=we_n=0, oe_n=1, addr=0x0010, sram_din=0xBEEF for 2 cycles; cpu_ack pulse 3 cycles after the grant edge. Then CPU read of 0x0010 (SRAM model) -> cpu_dout=0xBEEF when cpu_ack=1.
- Simultaneous: cpu_req and vga_req rise together, vga_addr=0x0200 holds 0x1234 -> VGA served first, vga_dout=0x1234. CPU granted on the very next IDLE; cpu_ack exactly 4 cycles after vga_ack.
- Starvation: vga_req held continuously (addresses 0x0000, 0x0001, ...) plus cpu_req held -> grant sequence VGA x4, CPU, VGA x4, CPU. Counter returns to 0 after each CPU grant.
- Isolation: VGA read of 0x0300=0xAAAA after CPU read returned 0x5555 -> vga_dout=0xAAAA, cpu_dout stays 0x5555; CPU write leaves cpu_dout unchanged.
- Reset mid-access: assert rst in the 1st ACCESS cycle of a CPU write -> next cycle all strobes=1, busy=0, no cpu_ack, all dout=0.
- Boundary address: VGA read at 0xFFFF, then CPU read at 0x0000 -> sram_addr exactly 0xFFFF then 0x0000; correct data returned to each requester.
